pc_update_ctrl: RTL and testbench
=================================

// Module: pc_update_ctrl
// PURPOSE
//  Sequencer that drives the PC-source mux select and the PC/EPC write strobes.
//  Main control pulses start with a request kind. This block selects the source
//  (ULA, AluOut, jump concat, MDR, EPC) and times pc_write.
//  For exceptions it runs the full sequence: save PC-4 into EPC, read the handler
//  byte from memory, latch it into MDR, then load PC from MDR.
// PARAMETERS
//  MEM_LATENCY   2    cycles mem_read is held before MDR data is valid (>=1)
//  EXC_VEC_BASE  253  byte address of handler byte for exception code 0
// PORTS
//  clk                       in   1   clock, rising edge
//  reset                     in   1   synchronous, active-high
//  start                     in   1   1-cycle request pulse from main control
//  req_kind                  in   3   000 seq, 001 branch, 010 jump, 011 rte, 100 exception
//  cond_true                 in   1   branch condition, sampled with start
//  exc_code                  in   2   0 bad opcode, 1 overflow, 2 div-by-zero; sampled with start
//  mux_pc_source_control     out  3   000 ULA, 001 AluOut, 010 concat, 011 MDR, 100 EPC
//  pc_write                  out  1   PC load strobe
//  epc_write                 out  1   EPC load strobe (EPC input = ULA result)
//  ula_sub_four              out  1   request ULA compute PC-4
//  mem_read                  out  1   memory read enable
//  exc_mem_addr              out  32  handler byte address
//  mdr_load                  out  1   MDR load strobe
//  busy                      out  1   high in every non-IDLE state
//  done                      out  1   1-cycle completion pulse
// BEHAVIOUR
//  Reset: state IDLE; every output 0 (mux select 000, exc_mem_addr 0).
//  Reset mid-sequence: outputs are 0 in the cycle after reset; no partial write completes.
//  Reset beats a start in the same cycle.
//  States: IDLE, WRITE, EXC_EPC, EXC_RD, EXC_MDR, EXC_PC.
//  IDLE: start is accepted only here. In any other state start is ignored and not queued.
//  Latched on accept: kind, cond_true, exc_code.
//   - Codes 101-111 are treated as exception code 0.
//   - exc_code 11 is treated as code 0.
//  Next state: WRITE for seq, branch, jump, rte; EXC_EPC for exceptions.
//  WRITE (1 cycle, then IDLE): done=1. Mux select by kind:
//   - seq 000, branch 001, jump 010, rte 100.
//   - pc_write=1, except for branch with cond_true=0 (pc_write=0, done still 1).
//   - Latency: start at cycle 0, pc_write and done in cycle 1.
//  EXC_EPC (1 cycle): ula_sub_four=1, epc_write=1.
//  EXC_RD (MEM_LATENCY cycles, down-counter): mem_read=1.
//   - exc_mem_addr = EXC_VEC_BASE + code, 32-bit zero-extended.
//   - The address is held from this state through EXC_PC.
//  EXC_MDR (1 cycle): mdr_load=1, mem_read=0.
//  EXC_PC (1 cycle): mux select 011, pc_write=1, done=1. Then IDLE; exc_mem_addr returns to 0.
//   - Exception latency: done in cycle 3+MEM_LATENCY (cycle 5 at default).
//  Strobe exclusivity:
//   - pc_write, epc_write, mdr_load: at most one high in any cycle.
//   - mux select is 000 outside WRITE and EXC_PC.
//   - busy=0 only in IDLE; a new start is accepted the cycle after done.
// TESTING
//  1. seq: start, kind 000 -> cycle 1: select 000, pc_write=1, done=1; cycle 2: busy=0.
//  2. branch: kind 001 with cond_true=1 -> select 001, pc_write=1.
//     cond_true=0 -> pc_write=0, done=1.
//  3. exc overflow, MEM_LATENCY=2:
//     - cycle 1: epc_write, ula_sub_four.
//     - cycles 2-3: mem_read, addr 254.
//     - cycle 4: mdr_load.
//     - cycle 5: select 011, pc_write, done.
//  4. kind 110, then exc_code 11 -> both run exception path with addr 253.
//  5. start pulsed during busy -> ignored; exactly one done.
//  6. reset in cycle 3 of exception -> next cycle all outputs 0, state IDLE.
//     The following start (jump) completes normally with select 010.

Source files
------------

// File: rtl/pc_update_ctrl.sv
// PC update sequencer: drives the PC-source mux select and the PC/EPC/MDR
// strobes for sequential, branch, jump, rte and exception requests.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, req_kind            one-cycle request pulse and its kind
//   cond_true, exc_code        branch condition / exception cause, taken with start
//   mux_pc_source_control      PC source select (ULA/AluOut/concat/MDR/EPC)
//   pc_write, epc_write        PC and EPC load strobes
//   ula_sub_four               ask the ULA for PC-4 (EPC input)
//   mem_read, exc_mem_addr     handler byte fetch
//   mdr_load                   MDR load strobe
//   busy, done                 sequencer activity and completion pulse
module pc_update_ctrl #(
    parameter int          MEM_LATENCY  = 2,
    parameter logic [31:0] EXC_VEC_BASE = 32'd253
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  req_kind,
    input  logic        cond_true,
    input  logic [1:0]  exc_code,
    output logic [2:0]  mux_pc_source_control,
    output logic        pc_write,
    output logic        epc_write,
    output logic        ula_sub_four,
    output logic        mem_read,
    output logic [31:0] exc_mem_addr,
    output logic        mdr_load,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WRITE   = 3'd1;
    localparam logic [2:0] S_EXC_EPC = 3'd2;
    localparam logic [2:0] S_EXC_RD  = 3'd3;
    localparam logic [2:0] S_EXC_MDR = 3'd4;
    localparam logic [2:0] S_EXC_PC  = 3'd5;

    localparam logic [2:0] K_SEQ    = 3'b000;
    localparam logic [2:0] K_BRANCH = 3'b001;
    localparam logic [2:0] K_JUMP   = 3'b010;
    localparam logic [2:0] K_RTE    = 3'b011;
    localparam logic [2:0] K_EXC    = 3'b100;

    localparam int CW = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);

    logic [2:0]    state_q, state_d;
    logic [2:0]    kind_q, kind_d;
    logic          cond_q, cond_d;
    logic [1:0]    code_q, code_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            kind_q  <= K_SEQ;
            cond_q  <= 1'b0;
            code_q  <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cond_q  <= cond_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cond_d  = cond_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    kind_d = req_kind;
                    cond_d = cond_true;
                    // Kinds 101-111 and cause 11 fall back to the
                    // bad-opcode handler (code 0).
                    if (req_kind == K_EXC && exc_code != 2'b11)
                        code_d = exc_code;
                    else
                        code_d = 2'd0;
                    state_d = req_kind[2] ? S_EXC_EPC : S_WRITE;
                end
            end
            S_WRITE:   state_d = S_IDLE;
            S_EXC_EPC: begin
                cnt_d   = CW'(MEM_LATENCY);
                state_d = S_EXC_RD;
            end
            S_EXC_RD: begin
                if (cnt_q <= CW'(1))
                    state_d = S_EXC_MDR;
                else
                    cnt_d = cnt_q - CW'(1);
            end
            S_EXC_MDR: state_d = S_EXC_PC;
            S_EXC_PC:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mux_pc_source_control = 3'b000;
        pc_write              = 1'b0;
        epc_write             = 1'b0;
        ula_sub_four          = 1'b0;
        mem_read              = 1'b0;
        exc_mem_addr          = 32'd0;
        mdr_load              = 1'b0;
        busy                  = (state_q != S_IDLE);
        done                  = 1'b0;
        case (state_q)
            S_WRITE: begin
                done = 1'b1;
                case (kind_q)
                    K_BRANCH: begin
                        mux_pc_source_control = 3'b001;
                        pc_write              = cond_q;
                    end
                    K_JUMP: begin
                        mux_pc_source_control = 3'b010;
                        pc_write              = 1'b1;
                    end
                    K_RTE: begin
                        mux_pc_source_control = 3'b100;
                        pc_write              = 1'b1;
                    end
                    default: begin
                        mux_pc_source_control = 3'b000;
                        pc_write              = 1'b1;
                    end
                endcase
            end
            S_EXC_EPC: begin
                ula_sub_four = 1'b1;
                epc_write    = 1'b1;
            end
            S_EXC_RD: begin
                mem_read     = 1'b1;
                exc_mem_addr = EXC_VEC_BASE + {30'd0, code_q};
            end
            S_EXC_MDR: begin
                mdr_load     = 1'b1;
                exc_mem_addr = EXC_VEC_BASE + {30'd0, code_q};
            end
            S_EXC_PC: begin
                mux_pc_source_control = 3'b011;
                pc_write              = 1'b1;
                done                  = 1'b1;
                exc_mem_addr          = EXC_VEC_BASE + {30'd0, code_q};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Scoreboard bench for pc_update_ctrl: a transaction-level model queues the
// expected per-cycle outputs; a monitor pops and compares every cycle.
module tb_pc_update_ctrl;

    localparam int ML = 2;
    localparam int BASE = 253;

    typedef struct packed {
        logic [2:0]  sel;
        logic        pcw;
        logic        epcw;
        logic        sub4;
        logic        mrd;
        logic [31:0] addr;
        logic        mdr;
        logic        busy;
        logic        done;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  req_kind;
    logic        cond_true;
    logic [1:0]  exc_code;
    logic [2:0]  mux_pc_source_control;
    logic        pc_write;
    logic        epc_write;
    logic        ula_sub_four;
    logic        mem_read;
    logic [31:0] exc_mem_addr;
    logic        mdr_load;
    logic        busy;
    logic        done;

    rec_t q[$];
    int   total = 0;
    int   bad = 0;
    int   ncyc = 0;
    bit   chk_en = 1'b0;

    pc_update_ctrl #(.MEM_LATENCY(ML), .EXC_VEC_BASE(32'd253)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .req_kind(req_kind),
        .cond_true(cond_true),
        .exc_code(exc_code),
        .mux_pc_source_control(mux_pc_source_control),
        .pc_write(pc_write),
        .epc_write(epc_write),
        .ula_sub_four(ula_sub_four),
        .mem_read(mem_read),
        .exc_mem_addr(exc_mem_addr),
        .mdr_load(mdr_load),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    function automatic rec_t idle_rec();
        rec_t r;
        r = '0;
        return r;
    endfunction

    // Expected cycle-by-cycle outputs for one accepted request.
    task automatic push_txn(input logic [2:0] k, input logic c,
                            input logic [1:0] e);
        rec_t r;
        int   code;
        if (k < 3'd4) begin
            r = '0;
            r.busy = 1'b1;
            r.done = 1'b1;
            r.sel = (k == 3'd3) ? 3'b100 : k;
            r.pcw = !(k == 3'd1 && !c);
            q.push_back(r);
        end else begin
            code = (k == 3'd4 && e != 2'd3) ? int'(e) : 0;
            r = '0;
            r.busy = 1'b1;
            r.epcw = 1'b1;
            r.sub4 = 1'b1;
            q.push_back(r);
            for (int i = 0; i < ML; i++) begin
                r = '0;
                r.busy = 1'b1;
                r.mrd = 1'b1;
                r.addr = 32'(BASE + code);
                q.push_back(r);
            end
            r = '0;
            r.busy = 1'b1;
            r.mdr = 1'b1;
            r.addr = 32'(BASE + code);
            q.push_back(r);
            r = '0;
            r.busy = 1'b1;
            r.sel = 3'b011;
            r.pcw = 1'b1;
            r.done = 1'b1;
            r.addr = 32'(BASE + code);
            q.push_back(r);
        end
    endtask

    // Drive one cycle; q[0] holds the expectation for the current cycle.
    task automatic step(input logic r, input logic s, input logic [2:0] k,
                        input logic c, input logic [1:0] e);
        reset = r;
        start = s;
        req_kind = k;
        cond_true = c;
        exc_code = e;
        if (r) begin
            while (q.size() > 1) void'(q.pop_back());
            q.push_back(idle_rec());
        end else if (q.size() == 1) begin
            if (s && !q[0].busy)
                push_txn(k, c, e);
            else
                q.push_back(idle_rec());
        end
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 1'b0, 2'd0);
    endtask

    always @(negedge clk) begin
        rec_t exp_r;
        rec_t act_r;
        if (chk_en) begin
            act_r.sel = mux_pc_source_control;
            act_r.pcw = pc_write;
            act_r.epcw = epc_write;
            act_r.sub4 = ula_sub_four;
            act_r.mrd = mem_read;
            act_r.addr = exc_mem_addr;
            act_r.mdr = mdr_load;
            act_r.busy = busy;
            act_r.done = done;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL underflow cyc=%0d: no expectation queued", ncyc);
            end else begin
                exp_r = q.pop_front();
                if (act_r !== exp_r) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got sel=%b pcw=%b epcw=%b sub4=%b mrd=%b addr=%0d mdr=%b busy=%b done=%b want sel=%b pcw=%b epcw=%b sub4=%b mrd=%b addr=%0d mdr=%b busy=%b done=%b",
                             ncyc, act_r.sel, act_r.pcw, act_r.epcw, act_r.sub4,
                             act_r.mrd, act_r.addr, act_r.mdr, act_r.busy,
                             act_r.done, exp_r.sel, exp_r.pcw, exp_r.epcw,
                             exp_r.sub4, exp_r.mrd, exp_r.addr, exp_r.mdr,
                             exp_r.busy, exp_r.done);
                end
            end
            total++;
            if (int'(pc_write) + int'(epc_write) + int'(mdr_load) > 1) begin
                bad++;
                $display("FAIL strobe_excl cyc=%0d got pcw=%b epcw=%b mdr=%b want at most one",
                         ncyc, pc_write, epc_write, mdr_load);
            end
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        req_kind = 3'd0;
        cond_true = 1'b0;
        exc_code = 2'd0;
        @(posedge clk);
        #1;
        q.push_back(idle_rec());
        chk_en = 1'b1;
        step(1'b1, 1'b1, 3'd2, 1'b0, 2'd0);
        idle(2);
        // seq
        step(1'b0, 1'b1, 3'd0, 1'b0, 2'd0);
        idle(2);
        // branch taken / not taken
        step(1'b0, 1'b1, 3'd1, 1'b1, 2'd0);
        idle(1);
        step(1'b0, 1'b1, 3'd1, 1'b0, 2'd0);
        idle(1);
        // jump, rte
        step(1'b0, 1'b1, 3'd2, 1'b0, 2'd0);
        idle(1);
        step(1'b0, 1'b1, 3'd3, 1'b0, 2'd0);
        idle(1);
        // overflow exception
        step(1'b0, 1'b1, 3'd4, 1'b0, 2'd1);
        idle(6);
        // kind 110, then exc_code 11, then div-by-zero
        step(1'b0, 1'b1, 3'd6, 1'b0, 2'd2);
        idle(6);
        step(1'b0, 1'b1, 3'd4, 1'b0, 2'd3);
        idle(6);
        step(1'b0, 1'b1, 3'd4, 1'b0, 2'd2);
        idle(6);
        // start pulsed while busy, then back-to-back after done
        step(1'b0, 1'b1, 3'd4, 1'b0, 2'd0);
        step(1'b0, 1'b1, 3'd2, 1'b0, 2'd0);
        step(1'b0, 1'b1, 3'd0, 1'b0, 2'd0);
        idle(2);
        step(1'b0, 1'b1, 3'd1, 1'b1, 2'd0);
        step(1'b0, 1'b1, 3'd1, 1'b1, 2'd0);
        step(1'b0, 1'b1, 3'd2, 1'b0, 2'd0);
        idle(2);
        // reset in cycle 3 of an exception, then a jump
        step(1'b0, 1'b1, 3'd4, 1'b0, 2'd1);
        idle(2);
        step(1'b1, 1'b0, 3'd0, 1'b0, 2'd0);
        step(1'b0, 1'b1, 3'd2, 1'b0, 2'd0);
        idle(2);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 2) == 0),
                 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)));
        end
        idle(8);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
